dram_cmd_scheduler: RTL and testbench

- Sequences one DDR-style memory request at a time into the `command_sender` command port.
- Per bank, tracks the open row (open-page policy) and decides whether the request is a row hit, a row miss on an idle bank, or a row conflict.
- Emits the needed PRECHARGE / ACTIVATE / READ / WRITE commands, spaced by the configured latencies.
- Sits between the memory-request front end (MSHR side) and `command_sender`.

---
 rtl/mem_sched_pkg.sv | 41 ++++
 rtl/address_parser.sv | 32 +++
 rtl/bank_state_table.sv | 53 +++++
 rtl/dram_cmd_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_dram_cmd_scheduler.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types for the DRAM command scheduler: command encoding, scheduler FSM states
// and the latched request record.
package mem_sched_pkg;

  localparam int REQ_ADDR_W = 64;
  localparam int LINE_WORDS = 8;
  localparam int WORD_W     = 64;

  typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

  typedef enum logic [2:0] {
    CMD_READ      = 3'd0,
    CMD_WRITE     = 3'd1,
    CMD_ACTIVATE  = 3'd2,
    CMD_PRECHARGE = 3'd3
  } cmd_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_PRE,
    S_ACT,
    S_WAIT_ACT,
    S_COL,
    S_GAP,
    S_CPRE,
    S_CWAIT
  } state_e;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic                  write;
    line_t                 data;
  } req_t;

  // States in which a command strobe is presented to command_sender.
  function automatic logic is_strobe(input state_e s);
    return (s == S_PRE) || (s == S_ACT) || (s == S_COL) || (s == S_CPRE);
  endfunction

endpackage

// File: rtl/address_parser.sv
// Physical address split into DRAM coordinates; fields from low to high are
// line offset [2:0], column, bank, bank group, row.
module address_parser #(
  parameter int PADDR_BITS = 64,
  parameter int COL_BITS   = 4,
  parameter int BANK_BITS  = 2,
  parameter int GROUP_BITS = 1,
  parameter int ROW_BITS   = 8
) (
  input  logic [PADDR_BITS-1:0] addr,
  output logic [COL_BITS-1:0]   col,
  output logic [BANK_BITS-1:0]  bank,
  output logic [GROUP_BITS-1:0] group,
  output logic [ROW_BITS-1:0]   row
);

  localparam int COL_LSB   = 3;
  localparam int BANK_LSB  = COL_LSB + COL_BITS;
  localparam int GROUP_LSB = BANK_LSB + BANK_BITS;
  localparam int ROW_LSB   = GROUP_LSB + GROUP_BITS;
  localparam int ADDR_TOP  = ROW_LSB + ROW_BITS;

  assign col   = addr[BANK_LSB-1:COL_LSB];
  assign bank  = addr[GROUP_LSB-1:BANK_LSB];
  assign group = addr[ROW_LSB-1:GROUP_LSB];
  assign row   = addr[ADDR_TOP-1:ROW_LSB];

  // Offset and bits above the row do not select anything in the DRAM.
  logic unused_bits;
  assign unused_bits = ^{addr[COL_LSB-1:0], addr[PADDR_BITS-1:ADDR_TOP]};

endmodule

// File: rtl/bank_state_table.sv
// Per-bank open flag and open row. Combinational lookup, registered set/clear update.
module bank_state_table #(
  parameter int BANK_GROUPS     = 2,
  parameter int BANKS_PER_GROUP = 4,
  parameter int ROW_BITS        = 8,
  localparam int BG_W = $clog2(BANK_GROUPS),
  localparam int BA_W = $clog2(BANKS_PER_GROUP)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BG_W-1:0]     lookup_bg,
  input  logic [BA_W-1:0]     lookup_ba,
  input  logic [ROW_BITS-1:0] lookup_row,
  output logic                hit,
  output logic                open,
  input  logic                set_en,
  input  logic                clr_en,
  input  logic [BG_W-1:0]     upd_bg,
  input  logic [BA_W-1:0]     upd_ba,
  input  logic [ROW_BITS-1:0] upd_row
);

  localparam int NB    = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int IDX_W = $clog2(NB);

  logic [NB-1:0]       open_q;
  logic [ROW_BITS-1:0] row_q [NB];
  logic [IDX_W-1:0]    lk_idx;
  logic [IDX_W-1:0]    upd_idx;

  function automatic logic [IDX_W-1:0] bank_idx(input logic [BG_W-1:0] bg,
                                                input logic [BA_W-1:0] ba);
    return IDX_W'(int'(bg) * BANKS_PER_GROUP + int'(ba));
  endfunction

  assign lk_idx  = bank_idx(lookup_bg, lookup_ba);
  assign upd_idx = bank_idx(upd_bg, upd_ba);
  assign open    = open_q[lk_idx];
  assign hit     = open_q[lk_idx] && (row_q[lk_idx] == lookup_row);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= '0;
      for (int i = 0; i < NB; i++) row_q[i] <= '0;
    end else if (set_en) begin
      open_q[upd_idx] <= 1'b1;
      row_q[upd_idx]  <= upd_row;
    end else if (clr_en) begin
      open_q[upd_idx] <= 1'b0;
    end
  end

endmodule

// File: rtl/dram_cmd_scheduler.sv
// One-request-at-a-time DDR command sequencer (PRECHARGE/ACTIVATE/READ/WRITE) feeding command_sender.
// Define DRAM_SCHED_CLOSED_PAGE_EN to precharge the bank after every access (closed-page policy).
module dram_cmd_scheduler
  import mem_sched_pkg::*;
#(
  parameter int CAS_LATENCY        = 22,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int BANK_GROUPS        = 2,
  parameter int BANKS_PER_GROUP    = 4,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int PADDR_BITS         = 64
) (
  input  logic                               clk_in,
  input  logic                               rst_N_in,
  input  logic                               req_valid_in,
  output logic                               req_ready_out,
  input  logic [PADDR_BITS-1:0]              req_addr_in,
  input  logic                               req_write_in,
  input  line_t                              req_data_in,
  output logic                               cmd_valid_out,
  output logic [2:0]                         cmd_out,
  output logic [$clog2(BANK_GROUPS)-1:0]     bank_group_out,
  output logic [$clog2(BANKS_PER_GROUP)-1:0] bank_out,
  output logic [ROW_BITS-1:0]                row_out,
  output logic [COL_BITS-1:0]                col_out,
  output line_t                              val_out,
  output logic                               row_hit_out
);

  localparam int BG_W      = $clog2(BANK_GROUPS);
  localparam int BA_W      = $clog2(BANKS_PER_GROUP);
  localparam int CNT_W     = $clog2(CAS_LATENCY + 9);
  localparam int READ_GAP  = CAS_LATENCY + 8;
  localparam int WRITE_GAP = 8;

`ifdef DRAM_SCHED_CLOSED_PAGE_EN
  localparam bit CLOSED_PAGE = 1'b1;
`else
  localparam bit CLOSED_PAGE = 1'b0;
`endif

  state_e              state_q, state_d, done_state;
  logic [CNT_W-1:0]    cnt_q, cnt_load;
  req_t                req_q;
  logic                idle, accept, strobe_d, cur_write, page_hit;
  logic [PADDR_BITS-1:0] parse_addr;
  logic [COL_BITS-1:0] dec_col;
  logic [BA_W-1:0]     dec_ba;
  logic [BG_W-1:0]     dec_bg;
  logic [ROW_BITS-1:0] dec_row;
  logic                lk_hit, lk_open, tbl_set, tbl_clr;
  cmd_e                cmd_q, cmd_d;
  logic                cmd_valid_q, row_hit_q;
  logic [BG_W-1:0]     bg_q;
  logic [BA_W-1:0]     ba_q;
  logic [ROW_BITS-1:0] row_q;
  logic [COL_BITS-1:0] col_q;

  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

  assign idle       = (state_q == S_IDLE);
  assign accept     = idle && req_valid_in;
  assign done_state = CLOSED_PAGE ? S_CPRE : S_IDLE;
  assign page_hit   = lk_hit && !CLOSED_PAGE;
  // While idle the incoming request is decoded for classification; afterwards the latched one.
  assign parse_addr = idle ? req_addr_in : PADDR_BITS'(req_q.addr);
  assign cur_write  = idle ? req_write_in : req_q.write;
  assign strobe_d   = is_strobe(state_d);

  address_parser #(
    .PADDR_BITS(PADDR_BITS),
    .COL_BITS  (COL_BITS),
    .BANK_BITS (BA_W),
    .GROUP_BITS(BG_W),
    .ROW_BITS  (ROW_BITS)
  ) u_address_parser (
    .addr (parse_addr),
    .col  (dec_col),
    .bank (dec_ba),
    .group(dec_bg),
    .row  (dec_row)
  );

  assign tbl_set = (state_q == S_ACT);
  assign tbl_clr = (state_q == S_PRE) || (state_q == S_CPRE);

  bank_state_table #(
    .BANK_GROUPS    (BANK_GROUPS),
    .BANKS_PER_GROUP(BANKS_PER_GROUP),
    .ROW_BITS       (ROW_BITS)
  ) u_bank_state_table (
    .clk       (clk_in),
    .rst_n     (rst_N_in),
    .lookup_bg (dec_bg),
    .lookup_ba (dec_ba),
    .lookup_row(dec_row),
    .hit       (lk_hit),
    .open      (lk_open),
    .set_en    (tbl_set),
    .clr_en    (tbl_clr),
    .upd_bg    (dec_bg),
    .upd_ba    (dec_ba),
    .upd_row   (dec_row)
  );

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // The counter is loaded on entry to a strobe state, so it already counts during the strobe cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_in) begin
          if (page_hit)     state_d = S_COL;
          else if (lk_open) state_d = S_PRE;
          else              state_d = S_ACT;
        end
      end
      S_PRE:      state_d = (cnt_q == '0) ? S_ACT : S_WAIT_PRE;
      S_WAIT_PRE: if (cnt_q == '0) state_d = S_ACT;
      S_ACT:      state_d = (cnt_q == '0) ? S_COL : S_WAIT_ACT;
      S_WAIT_ACT: if (cnt_q == '0) state_d = S_COL;
      S_COL:      state_d = (cnt_q == '0) ? done_state : S_GAP;
      S_GAP:      if (cnt_q == '0) state_d = done_state;
      S_CPRE:     state_d = (cnt_q == '0) ? S_IDLE : S_CWAIT;
      S_CWAIT:    if (cnt_q == '0) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_d    = CMD_READ;
    cnt_load = '0;
    unique case (state_d)
      S_PRE, S_CPRE: begin
        cmd_d    = CMD_PRECHARGE;
        cnt_load = lat_load(PRECHARGE_LATENCY);
      end
      S_ACT: begin
        cmd_d    = CMD_ACTIVATE;
        cnt_load = lat_load(ACTIVATION_LATENCY);
      end
      S_COL: begin
        cmd_d    = cur_write ? CMD_WRITE : CMD_READ;
        cnt_load = cur_write ? lat_load(WRITE_GAP) : lat_load(READ_GAP);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      cnt_q       <= '0;
      cmd_valid_q <= 1'b0;
      row_hit_q   <= 1'b0;
      cmd_q       <= CMD_READ;
      bg_q        <= '0;
      ba_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      cmd_valid_q <= strobe_d;
      row_hit_q   <= idle && (state_d == S_COL);
      if (strobe_d) begin
        cnt_q <= cnt_load;
        cmd_q <= cmd_d;
        bg_q  <= dec_bg;
        ba_q  <= dec_ba;
        row_q <= dec_row;
        col_q <= dec_col;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.addr  <= REQ_ADDR_W'(req_addr_in);
      req_q.write <= req_write_in;
      req_q.data  <= req_data_in;
    end
  end

  assign req_ready_out  = idle;
  assign cmd_valid_out  = cmd_valid_q;
  assign cmd_out        = cmd_q;
  assign bank_group_out = bg_q;
  assign bank_out       = ba_q;
  assign row_out        = row_q;
  assign col_out        = col_q;
  assign val_out        = req_q.data;
  assign row_hit_out    = row_hit_q;

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Scoreboard bench for dram_cmd_scheduler: directed requests push expected command strobes,
// a negedge monitor pops and compares them including the cycle they appear in.
`timescale 1ns/1ps
module tb_dram_cmd_scheduler;
  import mem_sched_pkg::*;

  localparam int T_PRE  = 5;
  localparam int T_ACT  = 8;
  localparam int RD_GAP = 30;
  localparam int WR_GAP = 8;
  localparam int K_HIT  = 0;
  localparam int K_MISS = 1;
  localparam int K_CONF = 2;
`ifdef DRAM_SCHED_CLOSED_PAGE_EN
  localparam bit CLOSED = 1'b1;
`else
  localparam bit CLOSED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  line_t       req_data = '0;
  logic        req_ready, cmd_valid, row_hit;
  logic [2:0]  cmd;
  logic [0:0]  bg;
  logic [1:0]  ba;
  logic [7:0]  row;
  logic [3:0]  col;
  line_t       val;

  dram_cmd_scheduler dut (
    .clk_in        (clk),
    .rst_N_in      (rst_n),
    .req_valid_in  (req_valid),
    .req_ready_out (req_ready),
    .req_addr_in   (req_addr),
    .req_write_in  (req_write),
    .req_data_in   (req_data),
    .cmd_valid_out (cmd_valid),
    .cmd_out       (cmd),
    .bank_group_out(bg),
    .bank_out      (ba),
    .row_out       (row),
    .col_out       (col),
    .val_out       (val),
    .row_hit_out   (row_hit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] cmd;
    logic [0:0] bg;
    logic [1:0] ba;
    logic [7:0] row;
    logic [3:0] col;
    logic       hit;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  always @(negedge clk) begin
    exp_t x;
    if (rst_n && cmd_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmd: got cmd=%0d bg=%0d ba=%0d row=%0d col=%0d at cycle %0d, required no command",
                 cmd, bg, ba, row, col, cyc);
      end else begin
        x = sb.pop_front();
        if (x.cyc != cyc || x.cmd !== cmd || x.bg !== bg || x.ba !== ba ||
            x.row !== row || x.col !== col || x.hit !== row_hit) begin
          errors++;
          $display("FAIL cmd_strobe: got cyc=%0d cmd=%0d bg=%0d ba=%0d row=%0d col=%0d hit=%0d, required cyc=%0d cmd=%0d bg=%0d ba=%0d row=%0d col=%0d hit=%0d",
                   cyc, cmd, bg, ba, row, col, row_hit, x.cyc, x.cmd, x.bg, x.ba, x.row, x.col, x.hit);
        end
      end
    end else if (rst_n && row_hit) begin
      checks++;
      errors++;
      $display("FAIL row_hit_alone: got row_hit=1 without strobe at cycle %0d, required 0", cyc);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h required=0x%0h", name, got, exp);
    end
  endtask

  task automatic chk_line(input string name, input line_t got, input line_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic push(input int c, input logic [2:0] k, input int b_g, input int b_a,
                      input int r, input int cl, input bit hit);
    exp_t x;
    x.cyc = c; x.cmd = k; x.bg = 1'(b_g); x.ba = 2'(b_a);
    x.row = 8'(r); x.col = 4'(cl); x.hit = hit;
    sb.push_back(x);
  endtask

  // Expected strobes for one request accepted at edge e; rdy is the cycle ready returns.
  task automatic expect_req(input int e, input int kind, input int b_g, input int b_a,
                            input int r, input int cl, input bit wr, output int rdy);
    int c = e;
    int k = CLOSED ? K_MISS : kind;
    if (k == K_CONF) begin
      push(c, CMD_PRECHARGE, b_g, b_a, r, cl, 1'b0);
      c += T_PRE;
    end
    if (k != K_HIT) begin
      push(c, CMD_ACTIVATE, b_g, b_a, r, cl, 1'b0);
      c += T_ACT;
    end
    push(c, wr ? CMD_WRITE : CMD_READ, b_g, b_a, r, cl, k == K_HIT);
    c += wr ? WR_GAP : RD_GAP;
    if (CLOSED) begin
      push(c, CMD_PRECHARGE, b_g, b_a, r, cl, 1'b0);
      c += T_PRE;
    end
    rdy = c;
  endtask

  task automatic send(input logic [63:0] a, input logic w, input line_t d, output int e);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_before_send", 64'(req_ready), 64'd1);
    req_addr = a; req_write = w; req_data = d; req_valid = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_ready(input int rc, input string name);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk(name, 64'(cyc), 64'(rc));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_row_hit"}, 64'(row_hit), 64'd0);
    chk({tag, "_cmd"}, 64'(cmd), 64'(CMD_READ));
    chk({tag, "_addr_outs"}, 64'({bg, ba, row, col}), 64'd0);
    chk_line({tag, "_val"}, val, '0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish by 50000ns, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e2, rc, rc2;
    line_t d1, d2, d3;
    for (int i = 0; i < 8; i++) begin
      d1[i] = {32'hA5A5_0000 | 32'(i), 32'h1000_0000 + 32'(i)};
      d2[i] = {32'h5A5A_0000 | 32'(i), 32'h2000_0000 + 32'(i)};
      d3[i] = {32'hC3C3_0000 | 32'(i), 32'h3000_0000 + 32'(i)};
    end

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(64'h400, 1'b0, '0, e);
    expect_req(e, K_MISS, 0, 0, 1, 0, 1'b0, rc);
    wait_ready(rc, "ready_after_read_400");

    send(64'h408, 1'b0, '0, e);
    expect_req(e, K_HIT, 0, 0, 1, 1, 1'b0, rc);
    wait_ready(rc, "ready_after_read_408");

    send(64'h480, 1'b0, '0, e);
    expect_req(e, K_MISS, 0, 1, 1, 0, 1'b0, rc);
    wait_ready(rc, "ready_after_read_480");

    send(64'h800, 1'b1, d1, e);
    expect_req(e, K_CONF, 0, 0, 2, 0, 1'b1, rc);
    chk_line("val_out_write_800", val, d1);
    wait_ready(rc, "ready_after_write_800");

    // valid held high across a busy period; the second request waits for the next IDLE
    req_addr = 64'h808; req_write = 1'b0; req_data = '0; req_valid = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    expect_req(e, K_HIT, 0, 0, 2, 1, 1'b0, rc);
    req_addr = 64'h810; req_write = 1'b1; req_data = d2;
    wait_ready(rc, "ready_held_valid_first");
    @(posedge clk); #1;
    e2 = cyc;
    req_valid = 1'b0;
    chk("held_valid_accept_edge", 64'(e2), 64'(rc + 1));
    expect_req(e2, K_HIT, 0, 0, 2, 2, 1'b1, rc2);
    chk_line("val_out_held_write", val, d2);
    wait_ready(rc2, "ready_held_valid_second");

    // reset while waiting after ACTIVATE
    send(64'h500, 1'b0, d3, e);
    push(e, CMD_ACTIVATE, 0, 2, 1, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midop_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(64'h408, 1'b0, '0, e);
    expect_req(e, K_MISS, 0, 0, 1, 1, 1'b0, rc);
    wait_ready(rc, "ready_after_reset_read");

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
